// File: rtl/adc_reader.sv
// Serial ADC frame reader: drives chip select and serial clock, shifts one
// MSB-first word per frame and hands it out through a valid/ready register.
module adc_reader #(
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned NBITS    = 16,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_QUIET = 4
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             adc_cs,
  output logic             adc_sclk,
  input  logic             adc_sdo,
  output logic [NBITS-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} state_e;

  localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0] QUIET_LAST = 8'(CS_QUIET - 1);
  localparam logic [7:0] DIV_LAST   = 8'(SCLK_DIV - 1);
  localparam logic [5:0] BIT_LAST   = 6'(NBITS - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;     // cycles within SETUP, QUIET or one sclk half-period
  logic [5:0]       bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             word_load;
  logic             xfer;

  assign xfer = valid_q & sample_ready;

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    word_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        // sclk_q doubles as the phase flag: low phase first, then high phase.
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            shift_d = (shift_q << 1) | NBITS'(adc_sdo);
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d   = QUIET;
              cs_d      = 1'b1;
              word_load = 1'b1;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load on the same edge as a transfer replaces the consumed word cleanly.
    if (word_load) begin
      sample_d = shift_q;
      valid_d  = 1'b1;
      if (valid_q && !xfer) ovr_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      // NOTE: the data registers are reset too, since sample is visible to
      // the consumer and must read zero after reset.
      sample_q <= '0;
      busy_q   <= 1'b0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign busy         = busy_q;
  assign adc_cs       = cs_q;
  assign adc_sclk     = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/adc_reader.md
ADC_READER -- requirements
Module: adc_reader

Interface
REQ-001 Parameter SCLK_DIV, default 4: clk_100M cycles per adc_sclk half-period; legal range 1..255.
REQ-002 Parameter NBITS, default 16: bits per conversion frame, MSB first; legal range 1..32.
REQ-003 Parameter CS_SETUP, default 2: cycles with adc_cs low before the first adc_sclk rise; legal range 1..255.
REQ-004 Parameter CS_QUIET, default 4: minimum cycles with adc_cs high between frames; legal range 1..255.
REQ-005 clk_100M  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request one conversion frame; sampled only in IDLE.
REQ-008 busy  out  1  high whenever the state is not IDLE.
REQ-009 adc_cs  out  1  ADC chip select, active low, idles high.
REQ-010 adc_sclk  out  1  ADC serial clock, idles low.
REQ-011 adc_sdo  in  1  ADC serial data, already synchronous to clk_100M.
REQ-012 sample  out  NBITS  last completed conversion word.
REQ-013 sample_valid  out  1  sample holds an unconsumed word.
REQ-014 sample_ready  in  1  consumer accepts sample on a cycle where sample_valid is also high.
REQ-015 overrun  out  1  sticky flag: a completed word overwrote an unconsumed word.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT and QUIET, and all outputs SHALL be registered.
REQ-017 IDLE with start=1 -> SETUP on the next edge; adc_cs drives low from that edge; start in any other state is ignored and not queued.
REQ-018 SETUP SHALL last exactly CS_SETUP cycles with adc_cs=0 and adc_sclk=0, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly 2*SCLK_DIV*NBITS cycles: per bit, adc_sclk is low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
REQ-020 On the edge that drives adc_sclk 0->1, adc_sdo SHALL be shifted into an internal register, MSB first; exactly NBITS rising edges occur per frame.
REQ-021 After the last high phase, the block SHALL enter QUIET with adc_sclk=0 and adc_cs=1, load sample with the shift register, and assert sample_valid=1 on that same edge.
REQ-022 QUIET SHALL last exactly CS_QUIET cycles and then go to IDLE; start held high SHALL give back-to-back frames.
REQ-023 busy SHALL be high for exactly CS_SETUP + 2*SCLK_DIV*NBITS + CS_QUIET cycles per frame (134 at defaults).
REQ-024 A transfer SHALL occur when sample_valid=1 and sample_ready=1 on the same edge, and sample_valid SHALL fall on the next edge unless a new word loads on that edge.
REQ-025 sample SHALL stay stable while sample_valid=1 and no new word loads.
REQ-026 If a new word loads while sample_valid=1 and there is no transfer on that edge, sample SHALL be overwritten, sample_valid SHALL stay 1, and overrun SHALL be set.
REQ-027 If a new word loads on the same edge as a transfer, sample SHALL be overwritten, sample_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-028 Once set, overrun SHALL be cleared only by rst.
REQ-029 Counters SHALL be sized for the parameter maxima, and no counter SHALL wrap within a frame.

Reset
REQ-030 When rst=1 on an edge, the following SHALL hold on the next cycle, from any state including mid-SHIFT:
- state IDLE, busy=0
- adc_cs=1, adc_sclk=0
- sample=0, sample_valid=0, overrun=0
- all counters and the shift register cleared
REQ-031 rst SHALL take priority over start and sample_ready on the same edge.

Verification
REQ-032 Defaults; one start pulse; adc_sdo drives 0xA5C3 MSB-first, changing on adc_sclk falls -> sample=0xA5C3; sample_valid rises 130 cycles after adc_cs falls; 16 adc_sclk rises, period 8 cycles; busy high for 134 cycles.
REQ-033 start pulsed during SHIFT -> no effect; exactly one frame, busy falls after 134 cycles.
REQ-034 sample_ready=0; two frames with 0x1234 then 0xBEEF -> sample=0xBEEF, sample_valid=1, overrun=1; then sample_ready=1 for one cycle -> sample_valid=0, overrun stays 1.
REQ-035 sample_ready rises on the edge where the second word loads -> sample = second word, sample_valid=1, overrun=0.
REQ-036 rst asserted after the 7th adc_sclk rise -> next cycle adc_cs=1, adc_sclk=0, busy=0, sample_valid=0; a following start yields a full correct frame.
REQ-037 SCLK_DIV=1, NBITS=8, adc_sdo=0x81 -> adc_sclk period 2 cycles; sample=0x81; busy high for 2+16+4=22 cycles.
